// File: rtl/hwpe_ctrl_vfpu_package.sv
// -----------------------------------------------------------------------------
// hwpe_ctrl_vfpu_package
// Shared types for the vfpu engine and the job-level stream sequencer in front
// of it: single-precision operand type, operation / rounding enums, the
// control and sticky-flag bundles, plus the sequencer FSM state and job record.
// -----------------------------------------------------------------------------
package hwpe_ctrl_vfpu_package;

  typedef logic [31:0] fp_t;

  typedef enum logic [1:0] {
    FP_OP_ADD = 2'd0,
    FP_OP_SUB = 2'd1,
    FP_OP_MUL = 2'd2,
    FP_OP_DIV = 2'd3
  } fp_op_t;

  typedef enum logic [1:0] {
    FP_RM_NEAREST  = 2'd0,
    FP_RM_ZERO     = 2'd1,
    FP_RM_PLUSINF  = 2'd2,
    FP_RM_MINUSINF = 2'd3
  } fp_rm_t;

  typedef struct packed {
    fp_op_t op;
    fp_rm_t rm;
  } ctrl_vfpu_t;

  // IEEE-754 exception flags: invalid, divide-by-zero, overflow, underflow,
  // inexact.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } flags_vfpu_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_RUN   = 3'd1,
    SEQ_DRAIN = 3'd2,
    SEQ_FLUSH = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

  // The job length is stored at its widest supported size; the sequencer
  // zero-extends its LEN_W-wide counters before comparing against it.
  localparam int unsigned SEQ_MAX_LEN_W = 32;

  typedef struct packed {
    logic [SEQ_MAX_LEN_W-1:0] len;
    fp_op_t                   op;
    fp_rm_t                   rm;
  } seq_job_t;

  localparam int unsigned SEQ_DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/vfpu_result_fifo.sv
// -----------------------------------------------------------------------------
// vfpu_result_fifo
// Registered result FIFO between the vfpu and the result stream. A pushed
// entry becomes visible on data_o the cycle after the push. Push and pop in
// the same cycle are allowed even when full. flush_i empties the FIFO and
// wins over a simultaneous push.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drop all entries
//   push_i, data_i  write side
//   pop_i           consume the head entry
//   data_o          head entry (0 while empty)
//   count_o         number of stored entries
//   empty_o, full_o status
// -----------------------------------------------------------------------------
module vfpu_result_fifo
  import hwpe_ctrl_vfpu_package::*;
#(
  parameter int unsigned DEPTH = SEQ_DEF_FIFO_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fp_t                    data_i,
  input  logic                   pop_i,
  output fp_t                    data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fp_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count do.
  // Stale entries are never observable because data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vfpu_stream_sequencer.sv
// -----------------------------------------------------------------------------
// vfpu_stream_sequencer
// Job-level controller in front of the vfpu. A job (len, op, rm) is latched on
// start_i; operand pairs are forwarded to the vfpu one per cycle, results are
// buffered in a registered FIFO and streamed out with valid/ready, and the
// vfpu flags are OR-ed into a sticky flags_o. done_o pulses once all results
// of the job have been consumed. clear_i aborts a running job (FLUSH).
//
// Issue is gated by a reservation rule: in-flight ops plus buffered results
// never exceed FIFO_DEPTH, so every returning result has a FIFO slot.
//
// Optional build macro VFPU_SEQ_TIMEOUT_EN adds the TIMEOUT_CYC parameter, a
// watchdog counter and the timeout_o output.
//
// Ports:
//   clk_i, rst_ni, clear_i           clock, async active-low reset, soft abort
//   start_i, len_i, op_i, rm_i       job request (sampled in IDLE)
//   busy_o, done_o, flags_o          job status
//   opA_i, opB_i, opnd_valid_i/ready operand stream in
//   res_o, res_valid_o, res_ready_i  result stream out
//   vfpu_*                           vfpu engine interface
//   timeout_o                        watchdog expiry (macro builds only)
// -----------------------------------------------------------------------------
module vfpu_stream_sequencer
  import hwpe_ctrl_vfpu_package::*;
#(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = SEQ_DEF_FIFO_DEPTH
`ifdef VFPU_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 256
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  fp_op_t           op_i,
  input  fp_rm_t           rm_i,
  output logic             busy_o,
  output logic             done_o,
  output flags_vfpu_t      flags_o,
  input  fp_t              opA_i,
  input  fp_t              opB_i,
  input  logic             opnd_valid_i,
  output logic             opnd_ready_o,
  output fp_t              res_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output fp_t              vfpu_opA_o,
  output fp_t              vfpu_opB_o,
  output ctrl_vfpu_t       vfpu_ctrl_o,
  output logic             vfpu_valid_o,
  input  logic             vfpu_ready_i,
  input  fp_t              vfpu_result_i,
  input  flags_vfpu_t      vfpu_flags_i,
  input  logic             vfpu_done_i
`ifdef VFPU_SEQ_TIMEOUT_EN
  ,
  output logic             timeout_o
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  seq_state_e       state_q, state_d;
  seq_job_t         job_q, job_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] completed_q, completed_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  flags_vfpu_t      flags_q, flags_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic             flush, room, all_issued, all_done;
  logic             issue, done_ok, push, pop, wd_fire;

  // ---------------------------------------------------------------------------
  // Handshake / bookkeeping terms
  // ---------------------------------------------------------------------------
  assign flush      = clear_i && (state_q != SEQ_IDLE);
  assign all_issued = (SEQ_MAX_LEN_W'(issued_q) == job_q.len);
  assign all_done   = (SEQ_MAX_LEN_W'(completed_q) == job_q.len);
  assign room       = (SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);

  assign issue = (state_q == SEQ_RUN) && !clear_i && opnd_valid_i && vfpu_ready_i &&
                 !all_issued && room;

  // A vfpu completion with nothing in flight is a protocol error and ignored.
  assign done_ok = vfpu_done_i && (inflight_q != '0);

  // Completions arriving while flushing (or in the abort cycle) are dropped.
  assign pop  = res_valid_o && res_ready_i;
  assign push = done_ok && !clear_i && (state_q inside {SEQ_RUN, SEQ_DRAIN}) &&
                (!fifo_full || pop);

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef VFPU_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_active;

  assign wd_active = (state_q inside {SEQ_RUN, SEQ_DRAIN, SEQ_FLUSH}) &&
                     (inflight_q != '0) && !vfpu_done_i;
  assign wd_fire   = wd_active && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d      = (wd_active && !wd_fire) ? wd_q + WD_W'(1) : '0;
    timeout_d = timeout_q | wd_fire;
    if (state_q == SEQ_IDLE && start_i) timeout_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Datapath next-state: job record, counters, sticky flags
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default at the top
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    job_d       = job_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    inflight_d  = inflight_q;
    flags_d     = flags_q;

    if (state_q == SEQ_IDLE && start_i) begin
      job_d       = '{len: SEQ_MAX_LEN_W'(len_i), op: op_i, rm: rm_i};
      issued_d    = '0;
      completed_d = '0;
      flags_d     = '0;
    end

    if (issue) issued_d = issued_q + LEN_W'(1);

    if (push) begin
      completed_d = completed_q + LEN_W'(1);
      flags_d     = flags_q | vfpu_flags_i;
    end

    case ({issue, done_ok})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (wd_fire) inflight_d = '0;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: begin
        if (start_i) state_d = (len_i == '0) ? SEQ_DONE : SEQ_RUN;
      end
      SEQ_RUN: begin
        if (flush)           state_d = SEQ_FLUSH;
        else if (wd_fire)    state_d = SEQ_DONE;
        else if (all_issued) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (flush)        state_d = SEQ_FLUSH;
        else if (wd_fire) state_d = SEQ_DONE;
        else if ((inflight_q == '0) && fifo_empty && all_done) state_d = SEQ_DONE;
      end
      SEQ_FLUSH: begin
        if (wd_fire || (inflight_q == '0)) state_d = SEQ_IDLE;
      end
      SEQ_DONE: begin
        state_d = flush ? SEQ_FLUSH : SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SEQ_IDLE;
      job_q       <= '{len: '0, op: FP_OP_ADD, rm: FP_RM_NEAREST};
      issued_q    <= '0;
      completed_q <= '0;
      inflight_q  <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      inflight_q  <= inflight_d;
      flags_q     <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o       = (state_q != SEQ_IDLE);
    done_o       = (state_q == SEQ_DONE);
    opnd_ready_o = issue;
    vfpu_valid_o = opnd_valid_i && issue;
  end

  assign vfpu_opA_o  = opA_i;
  assign vfpu_opB_o  = opB_i;
  assign vfpu_ctrl_o = '{op: job_q.op, rm: job_q.rm};
  assign flags_o     = flags_q;

  // ---------------------------------------------------------------------------
  // Result buffer
  // ---------------------------------------------------------------------------
  vfpu_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (vfpu_result_i),
    .pop_i   (pop),
    .data_o  (res_o),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign res_valid_o = !fifo_empty;

endmodule
